// File: rtl/sync_fifo_thresh.sv
// ---------------------------------------------------------------------------
// Module: sync_fifo_thresh
//
// Purpose:
//   Parametrised single-clock FIFO with occupancy count, programmable
//   almost-full / almost-empty flags and single-cycle overflow / underflow
//   error pulses. Intended as a drop-in buffer between a producer and a
//   consumer running on the same clock.
//
// Configuration macro:
//   FIFO_FWFT_EN  undefined -> standard mode: o_data is registered, a word
//                              popped at edge N shows up after edge N with
//                              o_rd_valid high for one cycle; o_data holds
//                              its last value otherwise.
//                 defined   -> first-word-fall-through: the head word is
//                              shown on o_data whenever the FIFO is not
//                              empty, o_rd_valid = !o_empty, and i_rd_en
//                              pops the displayed word.
//
// Parameters:
//   DATA_WIDTH     word width in bits (>= 1)
//   DEPTH          number of entries, power of 2, >= 2
//   AFULL_THRESH   o_almost_full  when count >= AFULL_THRESH  (1..DEPTH)
//   AEMPTY_THRESH  o_almost_empty when count <= AEMPTY_THRESH (0..DEPTH-1)
//
// Ports:
//   i_clk           clock, all logic on the rising edge
//   i_rst           synchronous active-high reset
//   i_wr_en/i_data  write request and write data
//   i_rd_en         read request
//   o_data          read data
//   o_rd_valid      o_data holds a valid popped / head word
//   o_empty         count == 0
//   o_full          count == DEPTH
//   o_almost_empty  count <= AEMPTY_THRESH
//   o_almost_full   count >= AFULL_THRESH
//   o_count         current occupancy, 0..DEPTH
//   o_overflow      1-cycle pulse: write dropped (full, no read)
//   o_underflow     1-cycle pulse: read ignored (empty)
// ---------------------------------------------------------------------------
module sync_fifo_thresh #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 32,
    parameter int AFULL_THRESH  = 28,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_rd_en,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     o_rd_valid,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_almost_empty,
    output logic                     o_almost_full,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_COUNT  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_COUNT = CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd_accept;
    logic                  w_wr_accept;

    // Status is decoded purely from the registered count, so no input
    // ever reaches a flag combinationally.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);

    // A write into a full FIFO is still taken when a read frees the slot in
    // the same cycle; a write never makes an empty FIFO readable.
    assign w_rd_accept = i_rd_en && !w_empty;
    assign w_wr_accept = i_wr_en && (!w_full || w_rd_accept);

    // Storage has no reset; stale words are never observable because the
    // pointers and count are cleared.
    always_ff @(posedge i_clk) begin
        if (w_wr_accept && !i_rst) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Error pulses last exactly one cycle since they are recomputed each edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= i_wr_en && w_full && !w_rd_accept;
            r_underflow <= i_rd_en && w_empty;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is shown directly; zero is driven while empty so the bus
    // does not expose stale storage.
    assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_rd_valid = !w_empty;
`else
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_rd_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_data     = r_data;
    assign o_rd_valid = r_rd_valid;
`endif

    assign o_empty        = w_empty;
    assign o_full         = w_full;
    assign o_almost_empty = (r_count <= AEMPTY_COUNT);
    assign o_almost_full  = (r_count >= AFULL_COUNT);
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// ---------------------------------------------------------------------------
// Testbench: tb_sync_fifo_thresh
//
// Purpose:
//   Self-checking bench for sync_fifo_thresh (DATA_WIDTH=16, DEPTH=8,
//   AFULL_THRESH=6, AEMPTY_THRESH=2). A queue-based reference model tracks
//   the FIFO contents; a table of fill/drain vectors carries hand-derived
//   expectations; directed sequences cover the full rd+wr, wrap and
//   mid-operation reset corners; a randomized phase finishes the run.
//   Honours FIFO_FWFT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_sync_fifo_thresh;

    localparam int DW     = 16;
    localparam int DEPTH  = 8;
    localparam int AFULL  = 6;
    localparam int AEMPTY = 2;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          wrEn;
    logic [DW-1:0] wrData;
    logic          rdEn;
    logic [DW-1:0] dutData;
    logic          dutValid;
    logic          dutEmpty;
    logic          dutFull;
    logic          dutAempty;
    logic          dutAfull;
    logic [CW-1:0] dutCount;
    logic          dutOvf;
    logic          dutUnf;

    int numChecks = 0;
    int numFails  = 0;

    sync_fifo_thresh #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .AFULL_THRESH  (AFULL),
        .AEMPTY_THRESH (AEMPTY)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_en        (wrEn),
        .i_data         (wrData),
        .i_rd_en        (rdEn),
        .o_data         (dutData),
        .o_rd_valid     (dutValid),
        .o_empty        (dutEmpty),
        .o_full         (dutFull),
        .o_almost_empty (dutAempty),
        .o_almost_full  (dutAfull),
        .o_count        (dutCount),
        .o_overflow     (dutOvf),
        .o_underflow    (dutUnf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as a plain queue plus the expected
    // registered side outputs after the most recent edge.
    logic [DW-1:0] modelQ[$];
    logic [DW-1:0] expData  = '0;
    bit            expValid = 1'b0;
    bit            expOvf   = 1'b0;
    bit            expUnf   = 1'b0;

    typedef struct {
        bit            wr;
        bit            rd;
        logic [DW-1:0] data;
        int            expCount;
        bit            expEmpty;
        bit            expFull;
        bit            expAempty;
        bit            expAfull;
        bit            expOvf;
        bit            expUnf;
    } vec_t;

    vec_t vecs[$];

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic modelStep(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
        bit rdOk;
        bit wrOk;
        if (r) begin
            modelQ.delete();
            expData  = '0;
            expValid = 1'b0;
            expOvf   = 1'b0;
            expUnf   = 1'b0;
        end else begin
            rdOk   = rd && (modelQ.size() != 0);
            wrOk   = w && ((modelQ.size() < DEPTH) || rdOk);
            expOvf = w && !wrOk;
            expUnf = rd && (modelQ.size() == 0);
            expValid = rdOk;
            if (rdOk) expData = modelQ.pop_front();
            if (wrOk) modelQ.push_back(d);
        end
`ifdef FIFO_FWFT_EN
        expValid = (modelQ.size() != 0);
        if (expValid) expData = modelQ[0];
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the same edge,
    // and leave the bench 1 time unit after the edge for sampling.
    task automatic applyStimulus(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
        rst    = r;
        wrEn   = w;
        wrData = d;
        rdEn   = rd;
        modelStep(r, w, d, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        int n;
        n = modelQ.size();
        checkEq({tag, ".count"},  32'(dutCount),  32'(n));
        checkEq({tag, ".empty"},  32'(dutEmpty),  32'(n == 0));
        checkEq({tag, ".full"},   32'(dutFull),   32'(n == DEPTH));
        checkEq({tag, ".aempty"}, 32'(dutAempty), 32'(n <= AEMPTY));
        checkEq({tag, ".afull"},  32'(dutAfull),  32'(n >= AFULL));
        checkEq({tag, ".ovf"},    32'(dutOvf),    32'(expOvf));
        checkEq({tag, ".unf"},    32'(dutUnf),    32'(expUnf));
        checkEq({tag, ".valid"},  32'(dutValid),  32'(expValid));
`ifdef FIFO_FWFT_EN
        if (expValid) checkEq({tag, ".data"}, 32'(dutData), 32'(expData));
`else
        checkEq({tag, ".data"}, 32'(dutData), 32'(expData));
`endif
    endtask

    task automatic resetDut(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b1, 1'b1, 16'hDEAD, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; wrEn = 1'b0; wrData = '0; rdEn = 1'b0;

        // Fill 0x0001..0x0009 (last write overflows), then drain 9 times
        // (last read underflows). Expectations written from the flag rules.
        for (int i = 1; i <= 9; i++) begin
            v.wr = 1'b1; v.rd = 1'b0; v.data = DW'(i);
            v.expCount  = (i > DEPTH) ? DEPTH : i;
            v.expEmpty  = 1'b0;
            v.expFull   = (v.expCount == DEPTH);
            v.expAempty = (v.expCount <= AEMPTY);
            v.expAfull  = (v.expCount >= AFULL);
            v.expOvf    = (i == 9);
            v.expUnf    = 1'b0;
            vecs.push_back(v);
        end
        for (int i = 1; i <= 9; i++) begin
            v.wr = 1'b0; v.rd = 1'b1; v.data = '0;
            v.expCount  = (i > DEPTH) ? 0 : DEPTH - i;
            v.expEmpty  = (v.expCount == 0);
            v.expFull   = 1'b0;
            v.expAempty = (v.expCount <= AEMPTY);
            v.expAfull  = (v.expCount >= AFULL);
            v.expOvf    = 1'b0;
            v.expUnf    = (i == 9);
            vecs.push_back(v);
        end

        // Reset held for two cycles with requests asserted (ignored).
        resetDut(2);
        checkOutput("reset");
        checkEq("reset.empty_const", 32'(dutEmpty), 32'd1);
        checkEq("reset.count_const", 32'(dutCount), 32'd0);

        foreach (vecs[k]) begin
            applyStimulus(1'b0, vecs[k].wr, vecs[k].data, vecs[k].rd);
            checkOutput($sformatf("vec%0d", k));
            checkEq($sformatf("vec%0d.tcount", k),  32'(dutCount),  32'(vecs[k].expCount));
            checkEq($sformatf("vec%0d.tempty", k),  32'(dutEmpty),  32'(vecs[k].expEmpty));
            checkEq($sformatf("vec%0d.tfull", k),   32'(dutFull),   32'(vecs[k].expFull));
            checkEq($sformatf("vec%0d.taempty", k), 32'(dutAempty), 32'(vecs[k].expAempty));
            checkEq($sformatf("vec%0d.tafull", k),  32'(dutAfull),  32'(vecs[k].expAfull));
            checkEq($sformatf("vec%0d.tovf", k),    32'(dutOvf),    32'(vecs[k].expOvf));
            checkEq($sformatf("vec%0d.tunf", k),    32'(dutUnf),    32'(vecs[k].expUnf));
`ifndef FIFO_FWFT_EN
            if (k >= 9 && k <= 16) checkEq($sformatf("vec%0d.tdata", k), 32'(dutData), 32'(k - 8));
`endif
        end

        // Full FIFO with simultaneous read+write of 0xAAAA.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, DW'(16'h0100 + i), 1'b0);
            checkOutput("fullrw.fill");
        end
        applyStimulus(1'b0, 1'b1, 16'hAAAA, 1'b1);
        checkOutput("fullrw.both");
        checkEq("fullrw.count_const", 32'(dutCount), 32'(DEPTH));
        checkEq("fullrw.noovf", 32'(dutOvf), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
`ifdef FIFO_FWFT_EN
            if (i == DEPTH - 1) checkEq("fullrw.lastword", 32'(dutData), 32'h0000AAAA);
`endif
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            checkOutput("fullrw.drain");
        end
`ifndef FIFO_FWFT_EN
        checkEq("fullrw.lastword", 32'(dutData), 32'h0000AAAA);
`endif

        // Wrap: hold occupancy at 3 across 20 simultaneous rd+wr cycles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, DW'(16'h2000 + i), 1'b0);
            checkOutput("wrap.prime");
        end
        for (int i = 3; i < 23; i++) begin
            applyStimulus(1'b0, 1'b1, DW'(16'h2000 + i), 1'b1);
            checkOutput("wrap.rw");
            checkEq("wrap.count3", 32'(dutCount), 32'd3);
        end

        // Reset at count 5, then a read must underflow.
        resetDut(1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, DW'(16'h3000 + i), 1'b0);
        checkEq("midrst.count5", 32'(dutCount), 32'd5);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("midrst.after");
        checkEq("midrst.empty", 32'(dutEmpty), 32'd1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("midrst.read");
        checkEq("midrst.unf", 32'(dutUnf), 32'd1);

        // Randomized traffic, with the write bias swinging to reach both ends.
        for (int i = 0; i < 600; i++) begin
            int wrPct;
            wrPct = ((i / 60) % 2 == 0) ? 70 : 30;
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 99) < wrPct),
                          DW'($urandom),
                          ($urandom_range(0, 99) < (100 - wrPct)));
            checkOutput("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
